aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
- Iterative AES key-schedule controller.
- Accepts a cipher key with a start handshake and expands it one 32-bit word per clock into an internal round-key register file.
- Serves 128-bit round keys by round index to the cipher round datapath.
- Replaces the flat all-keys-at-once expansion bus with a sequenced, area-lean schedule that round controllers can share.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8 for AES-128/192/256).
- Nb, 4, state columns in words (fixed at 4).
- Nr, 10, number of rounds (10/12/14, must match Nk).
- NW, Nb*(Nr+1), total expanded words (derived, localparam).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request expansion of key; sampled in IDLE or READY
- key  input  32*Nk  cipher key; MSB word is w[0] (FIPS-197 byte order)
- busy  output  1  expansion in progress
- keys_ready  output  1  all NW words valid
- rk_req  input  1  round-key read request
- rk_idx  input  4  round index 0..Nr
- rk_valid  output  1  read response strobe, one cycle after rk_req
- rk_data  output  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in bits 127:96
- rk_err  output  1  qualifies rk_valid: request rejected

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - busy=0, keys_ready=0, rk_valid=0, rk_err=0, rk_data=0.
  - Word index counter=0, rcon register=8'h01.
  - Word file contents are don't-care but must not be readable: keys_ready=0.
- FSM states: IDLE, EXPAND, READY.
- IDLE:
  - start=1: at the edge, load w[0..Nk-1] from key, set i=Nk, rcon=01, busy=1, go to EXPAND.
  - start=0: stay in IDLE.
- EXPAND: each edge computes w[i] = w[i-Nk] ^ temp, where temp is:
  - i mod Nk == 0: SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, then rcon = xtime(rcon) (02,04,...,80,1b,36).
  - Nk>6 and i mod Nk == 4: SubWord(w[i-1]).
  - otherwise: w[i-1].
  - i increments each edge.
  - When i==NW-1 is written: go to READY, busy=0, keys_ready=1 on the following cycle.
- Latency: start edge to keys_ready high is NW-Nk+1 cycles (41 for AES-128, 47 for AES-192, 53 for AES-256).
- start during EXPAND is ignored; no restart and no queueing.
- start in READY (re-key):
  - keys_ready drops the same edge; reload key, enter EXPAND.
  - An rk_req in that same cycle is rejected (rk_err=1).
- Round-key read:
  - rk_req sampled every cycle; response registered, rk_valid=1 exactly one cycle later.
  - State READY and rk_idx<=Nr: rk_data = round key, rk_err=0.
  - Not READY, or rk_idx>Nr: rk_data=0, rk_err=1.
  - rk_valid=0 in cycles without a preceding rk_req; rk_data is then held.
  - Back-to-back requests are supported: one response per cycle.
- rcon never wraps past 36 in legal configurations; index counter width is clog2(NW).
- Reset mid-expansion aborts immediately: keys_ready=0, and a new start is needed.

Decomposition:
- Shared package aes_pkg:
  - S-box table function.
  - xtime function.
  - rcon initial value.
  - Nk/Nr legal pairs as localparams.
  - Round-key width constant 128.
- One natural sub-module: aes_key_word.
  - Combinational.
  - Inputs: w_prev, w_back, rcon, mode (rot+sub / sub only / pass).
  - Output: next word.
  - Reused by the decrypt key path.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, pulse start:
  - keys_ready rises 41 cycles later.
  - Read idx 0 -> 2b7e151628aed2a6abf7158809cf4f3c.
  - Read idx 1 -> a0fafe1788542cb123a339392a6c7605.
  - Read idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reads during EXPAND and rk_idx=11 in READY -> rk_valid=1, rk_err=1, rk_data=0.
- Back-to-back reads idx 3,4,5 on consecutive cycles -> three consecutive rk_valid pulses with the correct keys, rk_err=0.
- Start pulsed mid-EXPAND (cycle 20) -> ignored; keys_ready still at cycle 41, and idx 10 matches the value above.
- rst_n asserted at cycle 15 then released, new start with the same key -> busy=0 and keys_ready=0 immediately; correct keys after 41 cycles.
- Nk=6/Nr=12 and Nk=8/Nr=14 instances with the FIPS-197 A.2/A.3 keys:
  - keys_ready after 47 and 53 cycles respectively.
  - Round key 0 equals the key's leading 128 bits.
  - Last round key matches the FIPS-197 appendix vector.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box, GF(2^8) doubling, key-schedule enums and legal Nk/Nr pairs.
package aes_pkg;

  localparam int NK_128 = 4;
  localparam int NR_128 = 10;
  localparam int NK_192 = 6;
  localparam int NR_192 = 12;
  localparam int NK_256 = 8;
  localparam int NR_256 = 14;

  localparam int RK_W = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_t;

  typedef enum logic [1:0] {
    KW_ROTSUB = 2'd0,
    KW_SUB    = 2'd1,
    KW_PASS   = 2'd2
  } kw_mode_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_word.sv
// One key-schedule step: next word from w[i-1] and w[i-Nk]; shared with the decrypt key path.
module aes_key_word
  import aes_pkg::*;
(
  input  logic [31:0] w_prev,
  input  logic [31:0] w_back,
  input  logic [7:0]  rcon,
  input  kw_mode_t    mode,
  output logic [31:0] w_next
);

  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;

  always_comb begin
    sub_in  = (mode == KW_ROTSUB) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = sub_word(sub_in);
    case (mode)
      KW_ROTSUB: temp = sub_out ^ {rcon, 24'h0};
      KW_SUB:    temp = sub_out;
      default:   temp = w_prev;
    endcase
    w_next = w_back ^ temp;
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key schedule: one expanded word per clock into a local word file,
// round keys served by index with a registered one-cycle response.
//   state  | meaning
//   IDLE   | no valid key material, waiting for start
//   EXPAND | writing w[i], i = Nk..NW-1, one word per clock
//   READY  | all words valid; start here re-keys
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nb = 4,
  parameter int Nr = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [32*Nk-1:0]  key,
  output logic              busy,
  output logic              keys_ready,
  input  logic              rk_req,
  input  logic [3:0]        rk_idx,
  output logic              rk_valid,
  output logic [RK_W-1:0]   rk_data,
  output logic              rk_err
);

  localparam int NW = Nb * (Nr + 1);
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] NK_W    = IW'(Nk);
  localparam logic [IW-1:0] LAST_W  = IW'(NW - 1);
  localparam logic [2:0]    NK_LAST = 3'(Nk - 1);
  localparam logic [3:0]    NR_IDX  = 4'(Nr);
  localparam bit            HAS_SUB4 = (Nk > 6);

  ks_state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [2:0]    phase;
  logic [7:0]    rcon;
  logic [31:0]   w_file [NW];
  logic [31:0]   w_next;
  kw_mode_t      mode;
  logic          load_key;
  logic          step;
  logic          rd_ok;
  logic [3:0]    rd_idx;
  logic [IW-1:0] rd_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_key = 1'b0;
    step     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_key = 1'b1;
          state_nx = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        step = 1'b1;
        if (idx == LAST_W) state_nx = ST_READY;
      end
      ST_READY: begin
        if (start) begin
          load_key = 1'b1;
          state_nx = ST_EXPAND;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    mode = KW_PASS;
    if (phase == 3'd0)                  mode = KW_ROTSUB;
    else if (HAS_SUB4 && phase == 3'd4) mode = KW_SUB;

    // a re-key edge overwrites the file, so a read in that cycle is refused
    rd_ok   = (state == ST_READY) && !start && (rk_idx <= NR_IDX);
    rd_idx  = (rk_idx <= NR_IDX) ? rk_idx : 4'd0;
    rd_base = IW'({rd_idx, 2'b00});
  end

  aes_key_word u_key_word (
    .w_prev (w_file[idx - IW'(1)]),
    .w_back (w_file[idx - NK_W]),
    .rcon   (rcon),
    .mode   (mode),
    .w_next (w_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      phase      <= '0;
      rcon       <= RCON_INIT;
      busy       <= 1'b0;
      keys_ready <= 1'b0;
    end else begin
      busy       <= (state_nx == ST_EXPAND);
      keys_ready <= (state == ST_READY) && (state_nx == ST_READY);
      if (load_key) begin
        idx   <= NK_W;
        phase <= '0;
        rcon  <= RCON_INIT;
      end else if (step) begin
        if (idx != LAST_W) idx <= idx + IW'(1);
        phase <= (phase == NK_LAST) ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0) rcon <= xtime(rcon);
      end
    end
  end

  // word file has no reset: keys_ready gates all reads
  always_ff @(posedge clk) begin
    if (load_key) begin
      for (int j = 0; j < Nk; j++) w_file[j] <= key[32*(Nk-1-j) +: 32];
    end else if (step) begin
      w_file[idx] <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      rk_data  <= '0;
    end else begin
      rk_valid <= rk_req;
      if (rk_req) begin
        rk_err  <= !rd_ok;
        rk_data <= rd_ok ? {w_file[rd_base], w_file[rd_base + IW'(1)],
                            w_file[rd_base + IW'(2)], w_file[rd_base + IW'(3)]} : '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: AES-128/192/256 instances against a GF(2^8) FIPS-197 reference model.
module tb_aes_key_sched_ctrl;

  logic          clk;
  logic          rst_n;
  logic [2:0]    start;
  logic [255:0]  key [3];
  logic [2:0]    busy;
  logic [2:0]    keys_ready;
  logic [2:0]    rk_req;
  logic [3:0]    rk_idx [3];
  logic [2:0]    rk_valid;
  logic [127:0]  rk_data [3];
  logic [2:0]    rk_err;

  int vectors = 0;
  int miscompares = 0;

  int nk_of [3] = '{4, 6, 8};
  int nr_of [3] = '{10, 12, 14};
  logic [7:0]  sb [256];
  logic [31:0] mw [3][60];

  localparam logic [255:0] KEY128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_sched_ctrl #(.Nk(4), .Nb(4), .Nr(10)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .key(key[0][127:0]),
    .busy(busy[0]), .keys_ready(keys_ready[0]), .rk_req(rk_req[0]), .rk_idx(rk_idx[0]),
    .rk_valid(rk_valid[0]), .rk_data(rk_data[0]), .rk_err(rk_err[0]));

  aes_key_sched_ctrl #(.Nk(6), .Nb(4), .Nr(12)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .key(key[1][191:0]),
    .busy(busy[1]), .keys_ready(keys_ready[1]), .rk_req(rk_req[1]), .rk_idx(rk_idx[1]),
    .rk_valid(rk_valid[1]), .rk_data(rk_data[1]), .rk_err(rk_err[1]));

  aes_key_sched_ctrl #(.Nk(8), .Nb(4), .Nr(14)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .key(key[2]),
    .busy(busy[2]), .keys_ready(keys_ready[2]), .rk_req(rk_req[2]), .rk_idx(rk_idx[2]),
    .rk_valid(rk_valid[2]), .rk_data(rk_data[2]), .rk_err(rk_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] m_sub(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input int u, input logic [255:0] k);
    int nk = nk_of[u];
    int nw = 4 * (nr_of[u] + 1);
    logic [7:0] rc = 8'h01;
    logic [31:0] t;
    for (int j = 0; j < nk; j++) mw[u][j] = k[32*(nk-1-j) +: 32];
    for (int i = nk; i < nw; i++) begin
      t = mw[u][i-1];
      if (i % nk == 0) begin
        t = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = m_sub(t);
      end
      mw[u][i] = mw[u][i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int u, input int r);
    return {mw[u][4*r], mw[u][4*r+1], mw[u][4*r+2], mw[u][4*r+3]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int u, input logic [255:0] k);
    key[u]   = k;
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
    chk("busy_after_start", 128'(busy[u]), 128'd1);
    chk("ready_low_after_start", 128'(keys_ready[u]), 128'd0);
  endtask

  task automatic wait_ready(input int u, input int lat);
    int n = 0;
    while (!keys_ready[u] && n < 200) begin
      tick();
      n++;
    end
    chk("ready_latency", 128'(n), 128'(lat));
    chk("busy_low_when_ready", 128'(busy[u]), 128'd0);
  endtask

  task automatic rd(input int u, input int idx, input logic [127:0] exp_data, input bit exp_err);
    rk_req[u] = 1'b1;
    rk_idx[u] = 4'(idx);
    tick();
    rk_req[u] = 1'b0;
    chk("rk_valid", 128'(rk_valid[u]), 128'd1);
    chk("rk_err", 128'(rk_err[u]), 128'(exp_err));
    chk("rk_data", rk_data[u], exp_err ? 128'd0 : exp_data);
  endtask

  task automatic rd_model(input int u, input int idx);
    bit e = (idx > nr_of[u]);
    rd(u, idx, e ? 128'd0 : model_rk(u, idx), e);
  endtask

  initial begin
    int lat;
    rst_n  = 1'b0;
    start  = '0;
    rk_req = '0;
    for (int u = 0; u < 3; u++) begin
      key[u]    = '0;
      rk_idx[u] = '0;
    end
    build_sbox();
    repeat (3) tick();

    for (int u = 0; u < 3; u++) begin
      chk("rst_busy", 128'(busy[u]), 128'd0);
      chk("rst_ready", 128'(keys_ready[u]), 128'd0);
      chk("rst_valid", 128'(rk_valid[u]), 128'd0);
      chk("rst_err", 128'(rk_err[u]), 128'd0);
      chk("rst_data", rk_data[u], 128'd0);
    end
    rst_n = 1'b1;
    tick();

    // AES-128 FIPS-197 vector
    model_expand(0, KEY128);
    do_start(0, KEY128);
    wait_ready(0, 41);
    rd(0, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    rd(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0);
    rd(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);
    rd(0, 11, 128'd0, 1'b1);

    for (int r = 3; r <= 5; r++) begin
      rk_req[0] = 1'b1;
      rk_idx[0] = 4'(r);
      tick();
      chk("b2b_valid", 128'(rk_valid[0]), 128'd1);
      chk("b2b_err", 128'(rk_err[0]), 128'd0);
      chk("b2b_data", rk_data[0], model_rk(0, r));
    end
    rk_req[0] = 1'b0;
    tick();
    chk("idle_valid_low", 128'(rk_valid[0]), 128'd0);
    chk("idle_data_held", rk_data[0], model_rk(0, 5));

    // re-key in READY with a same-cycle read, then stray start and read mid-expansion
    key[0]    = KEY128;
    start[0]  = 1'b1;
    rk_req[0] = 1'b1;
    rk_idx[0] = 4'd0;
    tick();
    start[0]  = 1'b0;
    rk_req[0] = 1'b0;
    chk("rekey_valid", 128'(rk_valid[0]), 128'd1);
    chk("rekey_err", 128'(rk_err[0]), 128'd1);
    chk("rekey_data", rk_data[0], 128'd0);
    chk("rekey_ready_drop", 128'(keys_ready[0]), 128'd0);
    chk("rekey_busy", 128'(busy[0]), 128'd1);
    lat = 0;
    while (!keys_ready[0] && lat < 200) begin
      start[0]  = (lat == 19);
      rk_req[0] = (lat == 10);
      rk_idx[0] = 4'd2;
      tick();
      lat++;
      if (lat == 11) begin
        chk("expand_rd_valid", 128'(rk_valid[0]), 128'd1);
        chk("expand_rd_err", 128'(rk_err[0]), 128'd1);
        chk("expand_rd_data", rk_data[0], 128'd0);
      end
      if (lat == 21) chk("stray_start_busy", 128'(busy[0]), 128'd1);
    end
    start[0]  = 1'b0;
    rk_req[0] = 1'b0;
    chk("stray_start_latency", 128'(lat), 128'd41);
    rd(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);

    // reset in the middle of an expansion
    do_start(0, KEY128);
    repeat (14) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy[0]), 128'd0);
    chk("midrst_ready", 128'(keys_ready[0]), 128'd0);
    tick();
    #2 rst_n = 1'b1;
    repeat (3) tick();
    chk("postrst_idle_busy", 128'(busy[0]), 128'd0);
    chk("postrst_idle_ready", 128'(keys_ready[0]), 128'd0);
    rd(0, 0, 128'd0, 1'b1);
    do_start(0, KEY128);
    wait_ready(0, 41);
    rd(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);

    // random keys on the AES-128 instance
    for (int t = 0; t < 3; t++) begin
      logic [255:0] rk = {128'd0, $urandom, $urandom, $urandom, $urandom};
      model_expand(0, rk);
      do_start(0, rk);
      wait_ready(0, 41);
      for (int q = 0; q < 6; q++) rd_model(0, int'($urandom_range(0, 15)));
      rd_model(0, 10);
    end

    // AES-192 and AES-256 FIPS-197 vectors
    model_expand(1, KEY192);
    do_start(1, KEY192);
    wait_ready(1, 47);
    rd(1, 0, 128'h8e73b0f7da0e6452c810f32b809079e5, 1'b0);
    rd(1, 12, 128'he98ba06f448c773c8ecc720401002202, 1'b0);
    rd(1, 13, 128'd0, 1'b1);
    for (int q = 0; q < 5; q++) rd_model(1, int'($urandom_range(0, 15)));

    model_expand(2, KEY256);
    do_start(2, KEY256);
    wait_ready(2, 53);
    rd(2, 0, 128'h603deb1015ca71be2b73aef0857d7781, 1'b0);
    rd(2, 14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0);
    rd(2, 15, 128'd0, 1'b1);
    for (int q = 0; q < 5; q++) rd_model(2, int'($urandom_range(0, 15)));

    // random 256-bit key re-keyed from READY
    begin
      logic [255:0] rk = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
      model_expand(2, rk);
      do_start(2, rk);
      wait_ready(2, 53);
      for (int r = 0; r <= 14; r += 7) rd_model(2, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
